executor_fun: RTL
=================

EXECUTOR_FUN -- requirements
Module: executor_fun

Interface
REQ-001 The block SHALL have parameter DUR0, default 4, meaning the duration in cycles of function 0, legal range 1..255.
REQ-002 The block SHALL have parameter DUR1, default 8, meaning the duration in cycles of function 1, legal range 1..255.
REQ-003 The block SHALL have parameter DUR2, default 16, meaning the duration in cycles of function 2, legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  3  function-request code from the function selector, one bit per function (bit n = function n).
REQ-007 abort  input  1  synchronous cancel of the running function.
REQ-008 ack  output  1  one-cycle pulse: request accepted.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 active  output  3  one-hot: the function currently executing.
REQ-011 done  output  1  one-cycle pulse: function completed normally.
REQ-012 aborted  output  1  one-cycle pulse: function cancelled.
REQ-013 multi  output  1  registered flag: the last accepted request had more than one bit set.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN, DONE and RELEASE; all outputs SHALL be registered.
REQ-015 IDLE, req != 0 at an edge: next cycle is RUN; ack=1 for that cycle; active = one-hot of the highest set req bit (priority 2 > 1 > 0); 8-bit counter loaded with DURn-1.
REQ-016 On acceptance, multi SHALL be set to 1 if popcount(req) > 1, else 0; it SHALL hold until the next acceptance.
REQ-017 IDLE, req == 0: remain in IDLE; no output change.
REQ-018 RUN, abort=0, counter != 0: counter decrements by 1; remain in RUN.
REQ-019 RUN, abort=0, counter == 0: next state is DONE; done=1 for one cycle; active is cleared in the same cycle.
REQ-020 active SHALL be nonzero for exactly DURn consecutive cycles for an uninterrupted run.
REQ-021 RUN, abort=1: next state is RELEASE; aborted=1 for one cycle; active is cleared; done stays 0; abort takes precedence over the counter reaching zero in the same cycle.
REQ-022 abort outside RUN SHALL be ignored.
REQ-023 DONE: unconditionally go to RELEASE the next cycle.
REQ-024 RELEASE: remain there while req != 0; go to IDLE on the first cycle req == 0. A request held constant therefore executes exactly once.
REQ-025 Changes on req during RUN, DONE or RELEASE SHALL NOT alter active, the counter, or the selected function.
REQ-026 ack, done and aborted SHALL be mutually exclusive in any cycle.
REQ-027 With DURn=1: ack and active set in the same cycle, followed by done on the next cycle.

Reset
REQ-028 reset=1 at an edge SHALL force: state IDLE, counter 0, ack 0, busy 0, active 000, done 0, aborted 0, multi 0.
REQ-029 reset SHALL override every other input, including when asserted mid-RUN; no done or aborted pulse is issued for the interrupted run.
REQ-030 The first request after reset deassertion SHALL be accepted on the first edge with req != 0.

Verification
REQ-031 req=001 for one cycle, defaults -> ack in cycle 1; active=001 in cycles 1-4; done in cycle 5; busy deasserted in cycle 7.
REQ-032 req=110 held -> active=100 for 16 cycles, multi=1, done once; no second ack until req=000 for one cycle and then a new request is applied.
REQ-033 req=010, abort asserted in the 3rd active cycle -> active cleared on the next cycle, aborted=1, done never asserted, RELEASE then IDLE once req=000.
REQ-034 reset asserted in the 5th cycle of a function-2 run -> all outputs match REQ-028 on the next cycle; no done or aborted pulse.
REQ-035 DUR0=1, req=001 pulse -> ack and active=001 in cycle 1, done in cycle 2.
REQ-036 req changes 001->100 during RUN -> active stays 001 for the full DUR0.

Source files
------------

// File: rtl/executor_fun.sv
// Function executor: accepts a one-hot-prioritised request, runs the selected
// function for its configured duration, and reports completion or cancellation.
module executor_fun #(
    parameter int unsigned DUR0 = 4,
    parameter int unsigned DUR1 = 8,
    parameter int unsigned DUR2 = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic       abort,
    output logic       ack,
    output logic       busy,
    output logic [2:0] active,
    output logic       done,
    output logic       aborted,
    output logic       multi
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic [7:0] LOAD0 = 8'(DUR0 - 1);
    localparam logic [7:0] LOAD1 = 8'(DUR1 - 1);
    localparam logic [7:0] LOAD2 = 8'(DUR2 - 1);

    logic [1:0] state;
    logic [7:0] count;
    logic [2:0] sel;
    logic [7:0] load;
    logic       multi_req;

    // Highest set request bit wins; the counter is loaded so that it reaches
    // zero in the last active cycle.
    always_comb begin
        sel  = 3'b000;
        load = 8'd0;
        if (req[2]) begin
            sel  = 3'b100;
            load = LOAD2;
        end else if (req[1]) begin
            sel  = 3'b010;
            load = LOAD1;
        end else if (req[0]) begin
            sel  = 3'b001;
            load = LOAD0;
        end
        multi_req = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= 8'd0;
            ack     <= 1'b0;
            busy    <= 1'b0;
            active  <= 3'b000;
            done    <= 1'b0;
            aborted <= 1'b0;
            multi   <= 1'b0;
        end else begin
            ack     <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 3'b000) begin
                        state  <= RUN;
                        ack    <= 1'b1;
                        busy   <= 1'b1;
                        active <= sel;
                        count  <= load;
                        multi  <= multi_req;
                    end
                end
                RUN: begin
                    // Cancellation wins over normal completion in the same cycle.
                    if (abort) begin
                        state   <= RELEASE;
                        aborted <= 1'b1;
                        active  <= 3'b000;
                        count   <= 8'd0;
                    end else if (count != 8'd0) begin
                        count <= count - 8'd1;
                    end else begin
                        state  <= DONE;
                        done   <= 1'b1;
                        active <= 3'b000;
                    end
                end
                DONE: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    // Waiting for req to drop keeps a held request from re-firing.
                    if (req == 3'b000) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
